id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Pipeline register between decode and the execute-stage ALU of the 16-bit RISC core. Captures one decoded instruction per handshake and resolves operand forwarding from the EX/MEM and MEM/WB stages. Selects register or immediate for operand B and detects load-use hazards, holding decode off for those cycles. Its registered outputs drive the ALU a/b/alu_cnt inputs and the downstream memory/writeback control directly.

Parameters:
DATA_W, 16, operand/result width
REG_AW, 3, register address width (8 registers; r0 reads as zero)
OP_W, 3, ALU control code width (0 add, 1 sub, 2 not, 3 shl, 4 shr, 5 and, 6 or, 7 slt)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill held and incoming instruction (branch taken)
in_valid  in  1  decode has an instruction
in_ready  out  1  stage accepts this cycle
in_rs_addr, in_rt_addr, in_rd_addr  in  REG_AW each  source/destination registers
in_rs_data, in_rt_data  in  DATA_W each  register-file read data
in_imm  in  DATA_W  sign/zero-extended immediate
in_use_imm  in  1  operand B = in_imm
in_alu_cnt  in  OP_W  ALU operation
in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits
exm_reg_write  in  1  EX/MEM instruction writes a register
exm_mem_read  in  1  EX/MEM instruction is a load (data not yet available)
exm_rd_addr  in  REG_AW;  exm_data  in  DATA_W  EX/MEM destination/result
wb_reg_write  in  1;  wb_rd_addr  in  REG_AW;  wb_data  in  DATA_W  writeback port
out_valid  out  1  held instruction valid
out_ready  in  1  execute consumes held instruction
out_a, out_b  out  DATA_W  ALU operands
out_alu_cnt  out  OP_W
out_store_data  out  DATA_W  forwarded rt value for stores
out_rd_addr  out  REG_AW
out_reg_write, out_mem_read, out_mem_write  out  1 each
hazard_stall  out  1  load-use stall active (for perf counters)

Behaviour:
- Reset (rst_n low, async): all outputs registers to 0; out_valid=0.
- Forwarding (combinational, per source s in {rs, rt}): s_addr==0 -> 0; else exm_reg_write && !exm_mem_read && exm_rd_addr==s_addr -> exm_data; else wb_reg_write && wb_rd_addr==s_addr -> wb_data; else register-file data. EX/MEM has priority over WB.
- Load-use hazard: exm_mem_read && exm_reg_write && exm_rd_addr!=0 && (exm_rd_addr==in_rs_addr || (exm_rd_addr==in_rt_addr && (!in_use_imm || in_mem_write))). hazard_stall = in_valid && hazard.
- in_ready = !flush && !hazard_stall && (!out_valid || out_ready). Purely combinational on out_ready.
- Capture on in_valid && in_ready at rising edge: out_a=fwd_rs; out_b = in_use_imm ? in_imm : fwd_rt; out_store_data=fwd_rt; controls copied; out_valid=1. Latency: one cycle, input to output.
- No capture and out_ready: out_valid->0. Held bubble: datapath outputs hold last values; control bits out_reg_write/out_mem_read/out_mem_write forced 0 when out_valid=0.
- out_valid && !out_ready: all outputs hold, in_ready=0.
- Hazard with free slot: a bubble is inserted (out_valid=0) and decode holds; it retries next cycle.
- flush (sync, highest priority): out_valid->0, control bits->0, no capture that cycle regardless of in_valid/out_ready.
- Reset asserted mid-transfer: immediate clear; first accept is possible on the first edge after rst_n rises.
- Widths: no arithmetic here; all values pass through at DATA_W. Shift amounts use full out_b.

Decomposition:
- Shared package cpu_pkg: DATA_W, REG_AW, OP_W, ALU op code constants (ALU_ADD..ALU_SLT), REG_ZERO.
- Sub-module fwd_mux (instantiated twice, for rs and rt): address compare plus priority select. Hazard logic and pipeline register stay in the top module.

Test Plan:
- Basic: in rs_data=0x0005, rt_data=0x0003, alu_cnt=1, out_ready=1 -> next cycle out_a=0x0005, out_b=0x0003, out_alu_cnt=1, out_valid=1.
- Forward priority: rs=2, exm_rd=2 with exm_data=0x1111, wb_rd=2 with wb_data=0x2222 -> out_a=0x1111. Drop the exm match -> 0x2222. rs=0 -> 0x0000.
- Load-use: exm_mem_read=1, exm_rd=3, in_rs_addr=3 -> in_ready=0, hazard_stall=1, out_valid=0 next cycle. Exm load clears -> captured the following cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid -> outputs stable, in_ready=0. out_ready=1 -> new instruction captured that edge.
- Flush: out_valid=1, flush=1, in_valid=1 -> next cycle out_valid=0, out_reg_write=0, no capture.
- Async reset: rst_n low mid-cycle with out_valid=1 -> out_valid=0 and all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, ALU op codes and control payload for the 16-bit RISC core.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_NOT = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_SHL = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_SHR = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_AND = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_OR  = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_SLT = OP_W'(7);

    localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

    // Memory/writeback control bits carried alongside an instruction.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register: r0, EX/MEM, WB, then register file.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd_data_c
);

    // A pending load in EX/MEM has no data yet, so it never forwards from there.
    always_comb begin
        fwd_data_c = rf_data;
        if (src_addr == REG_ZERO) begin
            fwd_data_c = '0;
        end else if (exm_reg_write && !exm_mem_read && (exm_rd_addr == src_addr)) begin
            fwd_data_c = exm_data;
        end else if (wb_reg_write && (wb_rd_addr == src_addr)) begin
            fwd_data_c = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, immediate select and load-use stall
// in front of the execute-stage ALU.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [OP_W-1:0]   in_alu_cnt,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP_W-1:0]   out_alu_cnt,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              hazard_stall
);

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              load_use;
    logic              rt_needed;
    logic              slot_free;
    logic              accept;
    ctrl_t             ctrl_q;

    fwd_mux u_fwd_rs (
        .src_addr      (in_rs_addr),
        .rf_data       (in_rs_data),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_rd_addr   (exm_rd_addr),
        .exm_data      (exm_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data_c    (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .src_addr      (in_rt_addr),
        .rf_data       (in_rt_data),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_rd_addr   (exm_rd_addr),
        .exm_data      (exm_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data_c    (fwd_rt)
    );

    // rt only matters when it feeds operand B or supplies store data.
    always_comb begin
        rt_needed = !in_use_imm || in_mem_write;
        load_use  = exm_mem_read && exm_reg_write && (exm_rd_addr != REG_ZERO) &&
                    ((exm_rd_addr == in_rs_addr) ||
                     ((exm_rd_addr == in_rt_addr) && rt_needed));
    end

    assign hazard_stall = in_valid && load_use;
    assign slot_free    = !out_valid || out_ready;
    assign in_ready     = !flush && !hazard_stall && slot_free;
    assign accept       = in_valid && in_ready;

    // Flush beats capture; an empty or drained slot turns into a bubble with control cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_a          <= '0;
            out_b          <= '0;
            out_alu_cnt    <= ALU_ADD;
            out_store_data <= '0;
            out_rd_addr    <= REG_ZERO;
            ctrl_q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_a          <= fwd_rs;
            out_b          <= in_use_imm ? in_imm : fwd_rt;
            out_alu_cnt    <= in_alu_cnt;
            out_store_data <= fwd_rt;
            out_rd_addr    <= in_rd_addr;
            ctrl_q         <= '{reg_write: in_reg_write,
                                mem_read:  in_mem_read,
                                mem_write: in_mem_write};
        end else if (slot_free) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end
    end

    assign out_reg_write = ctrl_q.reg_write;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_mem_write = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a behavioural stage model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic [15:0] in_rs_data, in_rt_data, in_imm;
    logic        in_use_imm;
    logic [2:0]  in_alu_cnt;
    logic        in_reg_write, in_mem_read, in_mem_write;
    logic        exm_reg_write, exm_mem_read;
    logic [2:0]  exm_rd_addr;
    logic [15:0] exm_data;
    logic        wb_reg_write;
    logic [2:0]  wb_rd_addr;
    logic [15:0] wb_data;
    logic        out_valid, out_ready;
    logic [15:0] out_a, out_b, out_store_data;
    logic [2:0]  out_alu_cnt, out_rd_addr;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic        hazard_stall;

    int errors = 0;
    int checks = 0;

    // Model of the held instruction
    logic        m_valid;
    logic [15:0] m_a, m_b, m_store;
    logic [2:0]  m_cnt, m_rd;
    logic        m_rw, m_mr, m_mw;

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs_addr     (in_rs_addr),
        .in_rt_addr     (in_rt_addr),
        .in_rd_addr     (in_rd_addr),
        .in_rs_data     (in_rs_data),
        .in_rt_data     (in_rt_data),
        .in_imm         (in_imm),
        .in_use_imm     (in_use_imm),
        .in_alu_cnt     (in_alu_cnt),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .exm_reg_write  (exm_reg_write),
        .exm_mem_read   (exm_mem_read),
        .exm_rd_addr    (exm_rd_addr),
        .exm_data       (exm_data),
        .wb_reg_write   (wb_reg_write),
        .wb_rd_addr     (wb_rd_addr),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_alu_cnt    (out_alu_cnt),
        .out_store_data (out_store_data),
        .out_rd_addr    (out_rd_addr),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .hazard_stall   (hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value an operand register holds from this stage's point of view.
    function automatic logic [15:0] ref_value(input logic [2:0] r, input logic [15:0] rf);
        logic [15:0] v;
        v = rf;
        if (wb_reg_write && wb_rd_addr == r) v = wb_data;
        if (exm_reg_write && !exm_mem_read && exm_rd_addr == r) v = exm_data;
        if (r == 3'd0) v = 16'h0000;
        return v;
    endfunction

    // Stall when the source registers actually read include a load still in flight.
    function automatic logic ref_stall();
        logic [2:0] srcs[$];
        srcs.push_back(in_rs_addr);
        if (!in_use_imm || in_mem_write) srcs.push_back(in_rt_addr);
        if (!(exm_mem_read && exm_reg_write) || exm_rd_addr == 3'd0) return 1'b0;
        foreach (srcs[i]) if (srcs[i] == exm_rd_addr) return in_valid;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_store = 0; m_cnt = 0; m_rd = 0;
        m_rw = 0; m_mr = 0; m_mw = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".valid"}, 16'(out_valid), 16'(m_valid));
        chk({tag, ".a"}, out_a, m_a);
        chk({tag, ".b"}, out_b, m_b);
        chk({tag, ".store"}, out_store_data, m_store);
        chk({tag, ".cnt"}, 16'(out_alu_cnt), 16'(m_cnt));
        chk({tag, ".rd"}, 16'(out_rd_addr), 16'(m_rd));
        chk({tag, ".ctrl"}, 16'({out_reg_write, out_mem_read, out_mem_write}),
            16'({m_rw, m_mr, m_mw}));
    endtask

    // Check handshake before the edge, advance the model, clock, then check outputs.
    task automatic tick(input string tag);
        logic stall, rdy;
        stall = ref_stall();
        rdy   = !flush && !stall && (!m_valid || out_ready);
        #1;
        chk({tag, ".hazard"}, 16'(hazard_stall), 16'(stall));
        chk({tag, ".in_ready"}, 16'(in_ready), 16'(rdy));
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1;
            m_a     = ref_value(in_rs_addr, in_rs_data);
            m_store = ref_value(in_rt_addr, in_rt_data);
            m_b     = in_use_imm ? in_imm : m_store;
            m_cnt   = in_alu_cnt;
            m_rd    = in_rd_addr;
            m_rw = in_reg_write; m_mr = in_mem_read; m_mw = in_mem_write;
        end else if (!m_valid || out_ready) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0;
        in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_use_imm = 0;
        in_alu_cnt = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
        exm_reg_write = 0; exm_mem_read = 0; exm_rd_addr = 0; exm_data = 0;
        wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
        out_ready = 1;
    endtask

    task automatic rand_inputs();
        flush         = ($urandom_range(15) == 0);
        in_valid      = ($urandom_range(3) != 0);
        in_rs_addr    = 3'($urandom_range(7));
        in_rt_addr    = 3'($urandom_range(7));
        in_rd_addr    = 3'($urandom_range(7));
        in_rs_data    = 16'($urandom);
        in_rt_data    = 16'($urandom);
        in_imm        = 16'($urandom);
        in_use_imm    = 1'($urandom_range(1));
        in_alu_cnt    = 3'($urandom_range(7));
        in_reg_write  = 1'($urandom_range(1));
        in_mem_read   = 1'($urandom_range(1));
        in_mem_write  = 1'($urandom_range(1));
        exm_reg_write = 1'($urandom_range(1));
        exm_mem_read  = ($urandom_range(3) == 0);
        exm_rd_addr   = 3'($urandom_range(7));
        exm_data      = 16'($urandom);
        wb_reg_write  = 1'($urandom_range(1));
        wb_rd_addr    = 3'($urandom_range(7));
        wb_data       = 16'($urandom);
        out_ready     = ($urandom_range(3) != 0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        check_outs("reset");
        chk("reset.in_ready", 16'(in_ready), 16'h1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Basic capture
        in_valid = 1; in_rs_addr = 1; in_rt_addr = 2; in_rd_addr = 4;
        in_rs_data = 16'h0005; in_rt_data = 16'h0003; in_alu_cnt = 3'd1; in_reg_write = 1;
        tick("basic");
        chk("basic.a_const", out_a, 16'h0005);
        chk("basic.b_const", out_b, 16'h0003);
        chk("basic.cnt_const", 16'(out_alu_cnt), 16'h0001);

        // Forward priority: EX/MEM over WB, then WB, then r0
        in_rs_addr = 2; exm_reg_write = 1; exm_rd_addr = 2; exm_data = 16'h1111;
        wb_reg_write = 1; wb_rd_addr = 2; wb_data = 16'h2222;
        tick("fwd_exm");
        chk("fwd_exm.const", out_a, 16'h1111);
        exm_reg_write = 0;
        tick("fwd_wb");
        chk("fwd_wb.const", out_a, 16'h2222);
        in_rs_addr = 0;
        tick("fwd_r0");
        chk("fwd_r0.const", out_a, 16'h0000);

        // Immediate operand and store data
        in_use_imm = 1; in_imm = 16'hBEEF; in_rt_addr = 5; in_rt_data = 16'h0055;
        in_mem_write = 1; in_reg_write = 0;
        tick("imm");
        chk("imm.b_const", out_b, 16'hBEEF);
        chk("imm.store_const", out_store_data, 16'h0055);
        in_use_imm = 0; in_mem_write = 0; in_reg_write = 1; wb_reg_write = 0;

        // Load-use stall then release
        exm_reg_write = 1; exm_mem_read = 1; exm_rd_addr = 3; in_rs_addr = 3;
        in_rs_data = 16'h0077;
        #1;
        chk("loaduse.stall_const", 16'(hazard_stall), 16'h1);
        chk("loaduse.ready_const", 16'(in_ready), 16'h0);
        tick("loaduse");
        chk("loaduse.bubble_const", 16'(out_valid), 16'h0);
        exm_reg_write = 0; exm_mem_read = 0;
        tick("loaduse_rel");
        chk("loaduse_rel.valid_const", 16'(out_valid), 16'h1);

        // Backpressure for three cycles, then release
        out_ready = 0; in_rs_addr = 6; in_rs_data = 16'hA5A5;
        for (int i = 0; i < 3; i++) begin
            tick("bp");
            chk("bp.a_hold", out_a, 16'h0077);
        end
        out_ready = 1;
        tick("bp_rel");
        chk("bp_rel.a_const", out_a, 16'hA5A5);

        // Flush with a valid incoming instruction
        flush = 1; in_rs_addr = 7; in_rs_data = 16'h3C3C;
        tick("flush");
        chk("flush.valid_const", 16'(out_valid), 16'h0);
        chk("flush.rw_const", 16'(out_reg_write), 16'h0);
        flush = 0;
        tick("refill");

        // Asynchronous reset mid-cycle while holding an instruction
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outs("async_rst");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
